// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel coordinates, sync pulses, active-video flag,
// line/frame start pulses and a look-ahead pixel request for the pixel FIFO.
// H_TOTAL and V_TOTAL must each be at most 4096. PREFETCH is legal from 0 to
// H_FP+H_SYNC+H_BP. All outputs are registered and share one cycle of latency
// relative to the main raster counters.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0,
  parameter int   PREFETCH = 2
) (
  input  logic        VGA_CLK,
  input  logic        a_reset,
  input  logic        en,
  output logic [11:0] dx,
  output logic [11:0] dy,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        active,
  output logic        line_start,
  output logic        frame_start,
  output logic        pix_req
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Linear raster index of the look-ahead position at reset, wrapped through
  // line and frame ends.
  localparam int LA_LIN  = PREFETCH % (H_TOTAL * V_TOTAL);

  localparam logic [11:0] H_MAX    = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_MAX    = 12'(V_TOTAL - 1);
  localparam logic [11:0] LHC_INIT = 12'(LA_LIN % H_TOTAL);
  localparam logic [11:0] LVC_INIT = 12'(LA_LIN / H_TOTAL);

  // Thresholds carried in 13 bits so a 4096-wide raster compares correctly.
  localparam logic [12:0] H_ACT_L = 13'(H_ACTIVE);
  localparam logic [12:0] HS_BEG  = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_FIN  = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_ACT_L = 13'(V_ACTIVE);
  localparam logic [12:0] VS_BEG  = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_FIN  = 13'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] hc_q, hc_d, vc_q, vc_d;
  logic [11:0] lhc_q, lhc_d, lvc_q, lvc_d;
  logic [11:0] dx_q, dx_d, dy_q, dy_d;
  logic        hs_q, hs_d, vs_q, vs_d;
  logic        active_q, active_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic        pix_req_q, pix_req_d;

  logic [12:0] hc_x, vc_x, lhc_x, lvc_x;

  assign hc_x  = {1'b0, hc_q};
  assign vc_x  = {1'b0, vc_q};
  assign lhc_x = {1'b0, lhc_q};
  assign lvc_x = {1'b0, lvc_q};

  // Counter advance and output decode; everything holds while en is low,
  // except the pulse/request outputs which drop to 0.
  always_comb begin
    hc_d          = hc_q;
    vc_d          = vc_q;
    lhc_d         = lhc_q;
    lvc_d         = lvc_q;
    dx_d          = dx_q;
    dy_d          = dy_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    active_d      = active_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    pix_req_d     = 1'b0;

    if (en) begin
      if (hc_q == H_MAX) begin
        hc_d = '0;
        vc_d = (vc_q == V_MAX) ? 12'd0 : vc_q + 12'd1;
      end else begin
        hc_d = hc_q + 12'd1;
      end

      if (lhc_q == H_MAX) begin
        lhc_d = '0;
        lvc_d = (lvc_q == V_MAX) ? 12'd0 : lvc_q + 12'd1;
      end else begin
        lhc_d = lhc_q + 12'd1;
      end

      dx_d          = hc_q;
      dy_d          = vc_q;
      active_d      = (hc_x < H_ACT_L) && (vc_x < V_ACT_L);
      hs_d          = ((hc_x >= HS_BEG) && (hc_x < HS_FIN)) ? SYNC_POL : ~SYNC_POL;
      vs_d          = ((vc_x >= VS_BEG) && (vc_x < VS_FIN)) ? SYNC_POL : ~SYNC_POL;
      line_start_d  = (hc_q == 12'd0);
      frame_start_d = (hc_q == 12'd0) && (vc_q == 12'd0);
      pix_req_d     = (lhc_x < H_ACT_L) && (lvc_x < V_ACT_L);
    end
  end

  // State and output registers.
  always_ff @(posedge VGA_CLK or negedge a_reset) begin
    if (!a_reset) begin
      hc_q          <= '0;
      vc_q          <= '0;
      lhc_q         <= LHC_INIT;
      lvc_q         <= LVC_INIT;
      dx_q          <= '0;
      dy_q          <= '0;
      hs_q          <= ~SYNC_POL;
      vs_q          <= ~SYNC_POL;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      pix_req_q     <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      lhc_q         <= lhc_d;
      lvc_q         <= lvc_d;
      dx_q          <= dx_d;
      dy_q          <= dy_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      pix_req_q     <= pix_req_d;
    end
  end

  assign dx          = dx_q;
  assign dy          = dy_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign active      = active_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign pix_req     = pix_req_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four instances (small raster with PREFETCH 2, 0
// with inverted sync polarity, 6, and the default 640x480 raster) share one
// clock, reset and enable. A linear-raster-index model predicts every output.
module tb_vga_timing_gen;

  localparam int NI = 4;
  localparam int HA [NI] = '{8, 8, 8, 640};
  localparam int HF [NI] = '{2, 2, 2, 16};
  localparam int HSW[NI] = '{2, 2, 2, 96};
  localparam int HB [NI] = '{2, 2, 2, 48};
  localparam int VA [NI] = '{4, 4, 4, 480};
  localparam int VF [NI] = '{1, 1, 1, 10};
  localparam int VSW[NI] = '{1, 1, 1, 2};
  localparam int VB [NI] = '{1, 1, 1, 33};
  localparam int PF [NI] = '{2, 0, 6, 2};
  localparam logic [NI-1:0] POLV = 4'b0010;

  logic clk;
  logic rst_n;
  logic en;
  logic chk_on;

  logic [NI-1:0][11:0] dx_a, dy_a;
  logic [NI-1:0]       hs_a, vs_a, act_a, ls_a, fs_a, pr_a;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Model state: number of enabled edges since reset, and en at the last edge.
  int m_cnt;
  bit m_en;

  typedef struct {
    int dx;
    int dy;
    bit hs;
    bit vs;
    bit act;
    bit ls;
    bit fs;
    bit pr;
  } exp_t;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    vga_timing_gen #(
      .H_ACTIVE(HA[g]), .H_FP(HF[g]), .H_SYNC(HSW[g]), .H_BP(HB[g]),
      .V_ACTIVE(VA[g]), .V_FP(VF[g]), .V_SYNC(VSW[g]), .V_BP(VB[g]),
      .SYNC_POL(POLV[g]), .PREFETCH(PF[g])
    ) u_dut (
      .VGA_CLK    (clk),
      .a_reset    (rst_n),
      .en         (en),
      .dx         (dx_a[g]),
      .dy         (dy_a[g]),
      .VGA_HS     (hs_a[g]),
      .VGA_VS     (vs_a[g]),
      .active     (act_a[g]),
      .line_start (ls_a[g]),
      .frame_start(fs_a[g]),
      .pix_req    (pr_a[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // After n enabled edges the outputs show raster index n-1; the request
  // looks PF pixels further along the same linear index.
  function automatic exp_t model(int k, int cnt, bit len);
    exp_t e;
    int ht, vt, ft, p, x, y, q;
    bit pol;
    pol = POLV[k];
    ht  = HA[k] + HF[k] + HSW[k] + HB[k];
    vt  = VA[k] + VF[k] + VSW[k] + VB[k];
    ft  = ht * vt;
    if (cnt == 0) begin
      e = '{0, 0, !pol, !pol, 1'b0, 1'b0, 1'b0, 1'b0};
    end else begin
      p     = (cnt - 1) % ft;
      x     = p % ht;
      y     = p / ht;
      e.dx  = x;
      e.dy  = y;
      e.hs  = (x >= HA[k] + HF[k] && x < HA[k] + HF[k] + HSW[k]) ? pol : !pol;
      e.vs  = (y >= VA[k] + VF[k] && y < VA[k] + VF[k] + VSW[k]) ? pol : !pol;
      e.act = (x < HA[k]) && (y < VA[k]);
      q     = (p + PF[k]) % ft;
      e.ls  = len && (x == 0);
      e.fs  = len && (x == 0) && (y == 0);
      e.pr  = len && ((q % ht) < HA[k]) && ((q / ht) < VA[k]);
    end
    return e;
  endfunction

  task automatic check(int k, string name, int act, int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL u%0d %s: got %0d, expected %0d (t=%0t)", k, name, act, exp, $time);
  endtask

  // Model update, mirroring the reset and enable seen by the DUTs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0;
      m_en  <= 1'b0;
    end else begin
      if (en) m_cnt <= m_cnt + 1;
      m_en <= en;
    end
  end

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < NI; k++) begin
        exp_t e;
        e = model(k, m_cnt, m_en);
        check(k, "dx",          int'(dx_a[k]),  e.dx);
        check(k, "dy",          int'(dy_a[k]),  e.dy);
        check(k, "VGA_HS",      int'(hs_a[k]),  int'(e.hs));
        check(k, "VGA_VS",      int'(vs_a[k]),  int'(e.vs));
        check(k, "active",      int'(act_a[k]), int'(e.act));
        check(k, "line_start",  int'(ls_a[k]),  int'(e.ls));
        check(k, "frame_start", int'(fs_a[k]),  int'(e.fs));
        check(k, "pix_req",     int'(pr_a[k]),  int'(e.pr));
      end
    end
  end

  initial begin
    int fs_seen, req, hs_low, first_low, first_ls, found, held_dy;
    rst_n  = 1'b0;
    en     = 1'b0;
    chk_on = 1'b0;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;

    check(0, "reset dx",      int'(dx_a[0]),  0);
    check(0, "reset hs",      int'(hs_a[0]),  1);
    check(1, "reset hs pol1", int'(hs_a[1]),  0);
    check(0, "reset active",  int'(act_a[0]), 0);
    check(0, "reset pix_req", int'(pr_a[0]),  0);

    rst_n = 1'b1;
    en    = 1'b1;
    @(negedge clk);
    check(0, "first dx",          int'(dx_a[0]),  0);
    check(0, "first active",      int'(act_a[0]), 1);
    check(0, "first line_start",  int'(ls_a[0]),  1);
    check(0, "first frame_start", int'(fs_a[0]),  1);
    check(0, "first pix_req",     int'(pr_a[0]),  1);

    // Two small frames at full enable.
    fs_seen = 0;
    req     = 0;
    for (int n = 2; n <= 196; n++) begin
      @(negedge clk);
      if (fs_a[0] && fs_seen == 0) fs_seen = n;
      if (n >= 99) req += int'(pr_a[0]);
      if (n == 9) check(2, "line1 request at dx8", int'(pr_a[2]), 1);
    end
    check(0, "frame period", fs_seen - 1, 98);
    check(0, "requests per frame", req, 32);

    // Finish the default raster's first line and start the next two.
    hs_low    = 0;
    first_low = -1;
    first_ls  = 0;
    for (int n = 197; n <= 1700; n++) begin
      @(negedge clk);
      if (dy_a[3] == 12'd0 && !hs_a[3]) begin
        hs_low++;
        if (first_low < 0) first_low = int'(dx_a[3]);
      end
      if (ls_a[3] && first_ls == 0) first_ls = n;
    end
    check(3, "hsync low width", hs_low, 96);
    check(3, "hsync first dx", first_low, 656);
    check(3, "line period", first_ls - 1, 800);

    // Stall for 5 cycles at dx=3.
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk);
      if (dx_a[0] == 12'd3) found = 1;
    end
    check(0, "reach dx3", found, 1);
    held_dy = int'(dy_a[0]);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check(0, "stall dx", int'(dx_a[0]), 3);
      check(0, "stall dy", int'(dy_a[0]), held_dy);
      check(0, "stall line_start", int'(ls_a[0]), 0);
      check(0, "stall pix_req", int'(pr_a[0]), 0);
    end
    en = 1'b1;
    @(negedge clk);
    check(0, "resume dx", int'(dx_a[0]), 4);

    // Random enable pattern.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      en = ($urandom_range(0, 3) != 0);
    end

    // Asynchronous reset at dx=5, dy=2.
    en = 1'b1;
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      @(negedge clk);
      if (dx_a[0] == 12'd5 && dy_a[0] == 12'd2) found = 1;
    end
    check(0, "reach dx5 dy2", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check(0, "async dx",     int'(dx_a[0]),  0);
    check(0, "async dy",     int'(dy_a[0]),  0);
    check(0, "async hs",     int'(hs_a[0]),  1);
    check(0, "async vs",     int'(vs_a[0]),  1);
    check(0, "async active", int'(act_a[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check(0, "release frame_start", int'(fs_a[0]), 1);
    check(0, "release dx", int'(dx_a[0]), 0);

    // Random enable with occasional mid-frame resets.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      en = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
